// File: rtl/demux_1_16_collect_if.sv
// Handshake and slot bundle between a serial word source and the 16-slot collector.
// slave = the collector, master = the producer/consumer side.
interface demux_1_16_collect_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_data;
    logic             use_select;
    logic [3:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       fill_cnt;
    logic [WIDTH-1:0] out_00, out_01, out_02, out_03;
    logic [WIDTH-1:0] out_04, out_05, out_06, out_07;
    logic [WIDTH-1:0] out_08, out_09, out_10, out_11;
    logic [WIDTH-1:0] out_12, out_13, out_14, out_15;

    modport slave (
        input  in_valid, input_data, use_select, select, out_ready,
        output in_ready, out_valid, fill_cnt,
        output out_00, out_01, out_02, out_03, out_04, out_05, out_06, out_07,
        output out_08, out_09, out_10, out_11, out_12, out_13, out_14, out_15
    );

    modport master (
        output in_valid, input_data, use_select, select, out_ready,
        input  in_ready, out_valid, fill_cnt,
        input  out_00, out_01, out_02, out_03, out_04, out_05, out_06, out_07,
        input  out_08, out_09, out_10, out_11, out_12, out_13, out_14, out_15
    );
endinterface

// File: rtl/demux_1_16_collect.sv
// 1:16 collector: steers serial words into 16 held slots and presents them
// as one parallel bundle once every slot has been written.
//
// state  | meaning
// S_FILL | accepting words; out_valid low
// S_HOLD | all 16 slots filled; bundle stable until out_ready or clear
module demux_1_16_collect #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    demux_1_16_collect_if.slave  bus
);
    typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

    state_t           state_q, state_nxt;
    logic [15:0]      filled_q, filled_nxt;
    logic [3:0]       wr_ptr_q, wr_ptr_nxt;
    logic [4:0]       fill_cnt_q, fill_cnt_nxt;
    logic [3:0]       idx;
    logic             accept;
    logic             flush;
    logic             in_ready_int;
    logic             out_valid_int;
    logic [WIDTH-1:0] slot_q [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            filled_q   <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            filled_q   <= filled_nxt;
            wr_ptr_q   <= wr_ptr_nxt;
            fill_cnt_q <= fill_cnt_nxt;
        end
    end

    // clear outranks everything; out_ready only matters once the bundle is held
    always_comb begin
        accept       = bus.in_valid & in_ready_int & ~clear;
        idx          = bus.use_select ? bus.select : wr_ptr_q;
        flush        = clear | ((state_q == S_HOLD) & bus.out_ready);
        state_nxt    = state_q;
        filled_nxt   = filled_q;
        wr_ptr_nxt   = wr_ptr_q;
        fill_cnt_nxt = fill_cnt_q;
        if (flush) begin
            state_nxt    = S_FILL;
            filled_nxt   = '0;
            wr_ptr_nxt   = '0;
            fill_cnt_nxt = '0;
        end else if (accept) begin
            filled_nxt   = filled_q | (16'h0001 << idx);
            wr_ptr_nxt   = idx + 4'd1;
            fill_cnt_nxt = fill_cnt_q + {4'd0, ~filled_q[idx]};
            if (&filled_nxt) begin
                state_nxt = S_HOLD;
            end
        end
    end

    always_comb begin
        in_ready_int  = (state_q == S_FILL);
        out_valid_int = (state_q == S_HOLD);
    end

    // slot data survives clear and bundle release; only reset zeroes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                slot_q[k] <= '0;
            end
        end else if (accept) begin
            slot_q[idx] <= bus.input_data;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.fill_cnt  = fill_cnt_q;
    assign bus.out_00    = slot_q[0];
    assign bus.out_01    = slot_q[1];
    assign bus.out_02    = slot_q[2];
    assign bus.out_03    = slot_q[3];
    assign bus.out_04    = slot_q[4];
    assign bus.out_05    = slot_q[5];
    assign bus.out_06    = slot_q[6];
    assign bus.out_07    = slot_q[7];
    assign bus.out_08    = slot_q[8];
    assign bus.out_09    = slot_q[9];
    assign bus.out_10    = slot_q[10];
    assign bus.out_11    = slot_q[11];
    assign bus.out_12    = slot_q[12];
    assign bus.out_13    = slot_q[13];
    assign bus.out_14    = slot_q[14];
    assign bus.out_15    = slot_q[15];
endmodule

// File: doc/demux_1_16_collect.md
Name: demux_1_16_collect

Overview:
- Reverse of the 16:1 selector used on the CNN datapath.
- Takes one WIDTH-bit word per handshake and steers it into one of 16 held output registers, out_00..out_15.
- When all 16 slots are filled, presents them as one parallel bundle with a valid/ready handshake.
- Sits where a serial result stream, such as per-channel accumulator outputs, must be re-parallelised for the next layer's 16-input stage.

Parameters:
WIDTH, 32, bit width of each data word and of each output slot.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort; discards the partial bundle.
in_valid  input  1  input_data is valid this cycle.
in_ready  output  1  block accepts a word this cycle.
input_data  input  WIDTH  word to store.
use_select  input  1  1 = write the slot given by select; 0 = write the slot given by the internal auto pointer.
select  input  4  explicit slot index, 0..15; used only when use_select=1.
out_valid  output  1  all 16 slots are filled and the bundle is stable.
out_ready  input  1  consumer takes the bundle.
fill_cnt  output  5  number of distinct slots filled, 0..16.
out_00 .. out_15  output  WIDTH each  slot registers, driven directly from flops.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FILL, wr_ptr=0, filled[15:0]=0, fill_cnt=0.
  - out_valid=0, in_ready=1 once reset is released.
  - All out_xx=0.
  - Reset asserted mid-bundle discards everything, with no out_valid pulse.
- State FILL:
  - in_ready=1, out_valid=0.
  - Accept condition: in_valid & in_ready & !clear.
  - On accept, idx = use_select ? select : wr_ptr.
  - out_idx <= input_data. The new value is visible on out_idx the cycle after the accepting edge.
  - filled[idx] <= 1.
  - wr_ptr <= idx+1 mod 16. This holds in both modes, so auto mode continues after the last explicit slot; 15 wraps to 0.
  - fill_cnt = popcount(filled), registered.
  - Rewriting an already-filled slot overwrites its data and leaves fill_cnt unchanged.
  - If the accept makes filled all ones, go to HOLD at the same edge. out_valid=1 and in_ready=0 from the next cycle.
- State HOLD:
  - in_ready=0, out_valid=1, fill_cnt=16.
  - All out_xx are held stable; in_valid is ignored and no write occurs.
  - On out_ready=1:
    - filled=0, wr_ptr=0, fill_cnt=0, state=FILL.
    - out_valid=0 and in_ready=1 from the next cycle, so there is a 1-cycle bubble between bundles.
    - out_xx keep their old values until overwritten.
  - out_ready while in FILL has no effect.
- clear (synchronous, highest priority after reset):
  - Forces state=FILL, filled=0, wr_ptr=0, fill_cnt=0.
  - Any write in that cycle is dropped.
  - out_xx data is not cleared.
  - clear in HOLD drops the bundle; out_valid deasserts next cycle.
- Simultaneous events:
  - clear together with out_ready: clear wins. The result is identical, with no extra handshake credit.
  - The 16th write and a same-cycle out_ready: out_ready is ignored because state is still FILL at that edge.
- select is sampled only on an accepting cycle; X on select is allowed otherwise.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Auto fill:
  - Stimulus: after reset, use_select=0, 16 back-to-back words 0x7000_0000+i, out_ready=0.
  - Response: out_i=0x7000_0000+i; fill_cnt steps 1..16; out_valid rises the cycle after the 16th accept; in_ready=0 while held.
- Hold and release:
  - Stimulus: in HOLD, drive in_valid=1 with 0xDEAD_BEEF for 5 cycles, then out_ready=1 for 1 cycle.
  - Response: outputs unchanged during the 5 cycles; out_valid falls and in_ready rises the next cycle; fill_cnt=0.
- Explicit select:
  - Stimulus: use_select=1 with select=15,14,…,0 and data 0x100+select.
  - Response: out_k=0x100+k; bundle completes on the 16th write.
  - Stimulus: rewrite slot 3 with 0x0333 after 4 writes.
  - Response: fill_cnt stays 4; out_03=0x0333.
- Mixed mode wrap:
  - Stimulus: select=14 explicit, then auto writes.
  - Response: auto writes land in slots 15 then 0, confirming the pointer wraps.
- Clear and reset:
  - Stimulus: after 7 writes assert clear with in_valid=1.
  - Response: write dropped; fill_cnt=0; the next auto write lands in slot 0.
  - Stimulus: assert rst_n=0 asynchronously mid-HOLD.
  - Response: out_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
- Boundary:
  - Stimulus: the 16th accept coincides with out_ready=1.
  - Response: out_valid still asserts next cycle and stays high until a later out_ready.
